// File: rtl/quad_uart_responder.sv
// Host command responder: parses 2-byte query/clear commands from the UART receiver
// and returns framed, XOR-checksummed replies through the transmitter handshake.
module quad_uart_responder #(
    parameter int         NUM_CH    = 4,
    parameter int         COUNT_W   = 32,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] OP_QUERY  = 8'h51,
    parameter logic [7:0] OP_CLEAR  = 8'h5A
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_data_ready,
    input  logic [7:0]                rx_data,
    input  logic                      rx_endofpacket,
    input  logic [NUM_CH*COUNT_W-1:0] count_flat,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    input  logic                      tx_busy,
    output logic [NUM_CH-1:0]         clr,
    output logic                      resp_active
);
    localparam int NB    = COUNT_W / 8;
    localparam int IDX_W = $clog2(NB + 3);

    typedef enum logic [2:0] {IDLE, GET_CH, SEND, WAIT_HI, WAIT_LO} state_t;

    function automatic logic [7:0] ckAccum(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t                     state_r;
    logic                       opClear_r;
    logic [7:0]                 byte1_r;
    logic [COUNT_W-1:0]         snapshot_r;
    logic [7:0]                 checksum_r;
    logic [IDX_W-1:0]           byteIdx_r;
    logic [IDX_W-1:0]           lastIdx_r;
    logic [1:0]                 waitCnt_r;
    logic                       txStart_r;
    logic [7:0]                 txData_r;
    logic [NUM_CH-1:0]          clr_r;
    logic                       respActive_r;

    logic                       chValid_s;
    logic [NUM_CH*COUNT_W-1:0]  cntShift_s;
    logic [COUNT_W-1:0]         chCount_s;
    logic [NUM_CH-1:0]          chOneHot_s;
    logic [COUNT_W-1:0]         snapShift_s;
    logic [7:0]                 curByte_s;

    // Decode the received channel byte into validity, selected count and clear one-hot.
    always_comb begin
        chValid_s  = (32'(rx_data) < 32'(NUM_CH));
        cntShift_s = count_flat >> (32'(rx_data) * 32'(COUNT_W));
        chCount_s  = cntShift_s[COUNT_W-1:0];
        chOneHot_s = NUM_CH'(1'b1) << rx_data;
    end

    // Select the frame byte at the current index; count bytes go out little-endian.
    always_comb begin
        snapShift_s = snapshot_r >> {byteIdx_r - IDX_W'(2), 3'b000};
        curByte_s   = SYNC_BYTE;
        if (byteIdx_r == IDX_W'(0)) begin
            curByte_s = SYNC_BYTE;
        end else if (byteIdx_r == IDX_W'(1)) begin
            curByte_s = byte1_r;
        end else if (byteIdx_r == lastIdx_r) begin
            curByte_s = checksum_r;
        end else begin
            curByte_s = snapShift_s[7:0];
        end
    end

    // Command parser and reply sequencer; every output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            opClear_r    <= 1'b0;
            byte1_r      <= 8'h00;
            snapshot_r   <= '0;
            checksum_r   <= 8'h00;
            byteIdx_r    <= '0;
            lastIdx_r    <= '0;
            waitCnt_r    <= 2'd0;
            txStart_r    <= 1'b0;
            txData_r     <= 8'h00;
            clr_r        <= '0;
            respActive_r <= 1'b0;
        end else begin
            clr_r     <= '0;
            txStart_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rx_data_ready && (rx_data == OP_QUERY || rx_data == OP_CLEAR)) begin
                        opClear_r <= (rx_data == OP_CLEAR);
                        state_r   <= GET_CH;
                    end
                end
                GET_CH: begin
                    // A byte arriving together with end-of-packet still completes the command.
                    if (rx_data_ready) begin
                        byteIdx_r    <= '0;
                        checksum_r   <= 8'h00;
                        respActive_r <= 1'b1;
                        state_r      <= SEND;
                        if (!chValid_s) begin
                            byte1_r   <= 8'h15;
                            lastIdx_r <= IDX_W'(2);
                        end else if (opClear_r) begin
                            byte1_r   <= 8'h80 | rx_data;
                            lastIdx_r <= IDX_W'(2);
                            clr_r     <= chOneHot_s;
                        end else begin
                            byte1_r    <= rx_data;
                            lastIdx_r  <= IDX_W'(NB + 2);
                            snapshot_r <= chCount_s;
                        end
                    end else if (rx_endofpacket) begin
                        state_r <= IDLE;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        txStart_r  <= 1'b1;
                        txData_r   <= curByte_s;
                        checksum_r <= ckAccum(checksum_r, curByte_s);
                        waitCnt_r  <= 2'd0;
                        state_r    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    // A transmitter that never raises busy must not stall the frame.
                    if (tx_busy || waitCnt_r == 2'd3) begin
                        state_r <= WAIT_LO;
                    end else begin
                        waitCnt_r <= waitCnt_r + 2'd1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (byteIdx_r == lastIdx_r) begin
                            respActive_r <= 1'b0;
                            state_r      <= IDLE;
                        end else begin
                            byteIdx_r <= byteIdx_r + IDX_W'(1);
                            state_r   <= SEND;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign tx_start    = txStart_r;
    assign tx_data     = txData_r;
    assign clr         = clr_r;
    assign resp_active = respActive_r;
endmodule

// File: tb/tb_quad_uart_responder.sv
// Randomized self-checking bench for quad_uart_responder with a frame-level reference model.
module tb_quad_uart_responder;
    localparam int NUM_CH  = 4;
    localparam int COUNT_W = 32;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] OPQ  = 8'h51;
    localparam logic [7:0] OPZ  = 8'h5A;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      rx_data_ready;
    logic [7:0]                rx_data;
    logic                      rx_endofpacket;
    logic [NUM_CH*COUNT_W-1:0] count_flat;
    logic                      tx_start;
    logic [7:0]                tx_data;
    logic                      tx_busy = 1'b0;
    logic [NUM_CH-1:0]         clr;
    logic                      resp_active;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobeCyc = 0;
    int busyMax = 2;
    int busyLeft = 0;
    int busyViol = 0;
    logic [7:0]        got[$];
    int                startCyc[$];
    logic [NUM_CH-1:0] clrLog[$];
    logic [7:0]        exp[$];

    quad_uart_responder #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
        .rx_endofpacket(rx_endofpacket), .count_flat(count_flat), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .clr(clr), .resp_active(resp_active)
    );

    always #5 clk = ~clk;

    // Transmitter model and output monitor, sampling 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rst_n) begin
                busyLeft = 0;
                tx_busy  = 1'b0;
            end else begin
                if (tx_start) begin
                    if (tx_busy) busyViol++;
                    got.push_back(tx_data);
                    startCyc.push_back(cyc);
                end
                if (busyLeft > 0) begin
                    busyLeft--;
                    if (busyLeft == 0) tx_busy = 1'b0;
                end
                if (tx_start && busyMax > 0) begin
                    busyLeft = $urandom_range(1, busyMax);
                    tx_busy  = 1'b1;
                end
                if (clr != '0) clrLog.push_back(clr);
            end
        end
    end

    // Reference frame built directly from the reply rules.
    function automatic void model(input logic [7:0] op, input logic [7:0] ch, input logic [COUNT_W-1:0] cnt);
        logic [7:0] x;
        exp.delete();
        exp.push_back(SYNC);
        if (ch >= NUM_CH) exp.push_back(8'h15);
        else if (op == OPZ) exp.push_back(8'h80 | ch);
        else begin
            exp.push_back(ch);
            for (int b = 0; b < COUNT_W / 8; b++) exp.push_back(cnt[8*b +: 8]);
        end
        x = 8'h00;
        foreach (exp[i]) x = x ^ exp[i];
        exp.push_back(x);
    endfunction

    function automatic logic [COUNT_W-1:0] cntOf(input int ch);
        return count_flat[ch*COUNT_W +: COUNT_W];
    endfunction

    task automatic sendByte(input logic [7:0] b, input logic eop);
        @(negedge clk);
        rx_data = b; rx_data_ready = 1'b1; rx_endofpacket = eop;
        @(posedge clk); #2;
        strobeCyc = cyc;
        @(negedge clk);
        rx_data_ready = 1'b0; rx_endofpacket = 1'b0;
    endtask

    task automatic sendEop();
        @(negedge clk); rx_endofpacket = 1'b1;
        @(negedge clk); rx_endofpacket = 1'b0;
    endtask

    task automatic waitDone(output logic timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (!resp_active) begin timedOut = 1'b0; break; end
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (clr !== 4'b0000) begin errors++; $display("FAIL reset_clr: got %b expected 0000", clr); end
        checks++; if (resp_active !== 1'b0) begin errors++; $display("FAIL reset_resp_active: got %b expected 0", resp_active); end
    endtask

    task automatic test_query();
        int base, cbase, n, lat;
        logic to;
        busyMax = 3;
        base = got.size(); cbase = clrLog.size();
        count_flat[2*COUNT_W +: COUNT_W] = 32'h12345678;
        sendByte(OPQ, 1'b0); sendByte(8'h02, 1'b0);
        checks++; if (resp_active !== 1'b1) begin errors++; $display("FAIL query_active: got %b expected 1", resp_active); end
        count_flat[2*COUNT_W +: COUNT_W] = 32'hFFFF0000;
        waitDone(to);
        checks++; if (to) begin errors++; $display("FAIL query_timeout: resp_active stuck high, expected drop"); end
        exp = '{8'hA5, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAF};
        n = got.size() - base;
        checks++; if (n != 7) begin errors++; $display("FAIL query_len: got %0d tx_start pulses expected 7", n); end
        for (int i = 0; i < exp.size() && i < n; i++) begin
            checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL query_byte%0d: got %h expected %h", i, got[base+i], exp[i]); end
        end
        lat = (n > 0) ? startCyc[base] - strobeCyc : 99;
        checks++; if (lat > 2) begin errors++; $display("FAIL query_latency: got %0d cycles expected <=2", lat); end
        checks++; if (clrLog.size() != cbase) begin errors++; $display("FAIL query_clr: got %0d pulses expected 0", clrLog.size() - cbase); end
    endtask

    task automatic test_clear();
        int base, cbase, n;
        logic to;
        base = got.size(); cbase = clrLog.size();
        sendByte(OPZ, 1'b0); sendByte(8'h01, 1'b0);
        waitDone(to);
        checks++; if (to) begin errors++; $display("FAIL clear_timeout: resp_active stuck high"); end
        exp = '{8'hA5, 8'h81, 8'h24};
        n = got.size() - base;
        checks++; if (n != 3) begin errors++; $display("FAIL clear_len: got %0d expected 3", n); end
        for (int i = 0; i < exp.size() && i < n; i++) begin
            checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL clear_byte%0d: got %h expected %h", i, got[base+i], exp[i]); end
        end
        n = clrLog.size() - cbase;
        checks++; if (n != 1) begin errors++; $display("FAIL clear_pulse_cycles: got %0d expected 1", n); end
        if (n == 1) begin
            checks++; if (clrLog[cbase] !== 4'b0010) begin errors++; $display("FAIL clear_value: got %b expected 0010", clrLog[cbase]); end
        end
    endtask

    task automatic test_nak();
        int base, cbase, n;
        logic to;
        for (int k = 0; k < 2; k++) begin
            base = got.size(); cbase = clrLog.size();
            sendByte((k == 0) ? OPQ : OPZ, 1'b0); sendByte((k == 0) ? 8'h07 : 8'h09, 1'b0);
            waitDone(to);
            checks++; if (to) begin errors++; $display("FAIL nak_timeout: resp_active stuck high"); end
            exp = '{8'hA5, 8'h15, 8'hB0};
            n = got.size() - base;
            checks++; if (n != 3) begin errors++; $display("FAIL nak_len: got %0d expected 3", n); end
            for (int i = 0; i < exp.size() && i < n; i++) begin
                checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL nak_byte%0d: got %h expected %h", i, got[base+i], exp[i]); end
            end
            checks++; if (clrLog.size() != cbase) begin errors++; $display("FAIL nak_clr: got %0d pulses expected 0", clrLog.size() - cbase); end
        end
    endtask

    task automatic test_abort_ignore();
        int base, n;
        logic to;
        base = got.size();
        sendByte(OPQ, 1'b0); sendEop(); sendByte(8'h02, 1'b0);
        sendByte(8'h33, 1'b0); sendByte(8'h01, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        checks++; if (got.size() != base) begin errors++; $display("FAIL abort_reply: got %0d bytes expected 0", got.size() - base); end
        checks++; if (resp_active !== 1'b0) begin errors++; $display("FAIL abort_active: got %b expected 0", resp_active); end
        // Channel byte coinciding with end-of-packet still completes the command.
        sendByte(OPQ, 1'b0); sendByte(8'h03, 1'b1);
        model(OPQ, 8'h03, cntOf(3));
        waitDone(to);
        n = got.size() - base;
        checks++; if (n != exp.size()) begin errors++; $display("FAIL eop_same_len: got %0d expected %0d", n, exp.size()); end
        for (int i = 0; i < exp.size() && i < n; i++) begin
            checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL eop_same_byte%0d: got %h expected %h", i, got[base+i], exp[i]); end
        end
    endtask

    task automatic test_drop_during_reply();
        int base, cbase, n;
        logic to;
        busyMax = 4;
        base = got.size(); cbase = clrLog.size();
        count_flat[1*COUNT_W +: COUNT_W] = $urandom;
        sendByte(OPQ, 1'b0); sendByte(8'h01, 1'b0);
        model(OPQ, 8'h01, cntOf(1));
        sendByte(OPZ, 1'b0); sendByte(8'h00, 1'b0);
        waitDone(to);
        repeat (20) @(posedge clk);
        #2;
        n = got.size() - base;
        checks++; if (n != exp.size()) begin errors++; $display("FAIL drop_len: got %0d expected %0d", n, exp.size()); end
        for (int i = 0; i < exp.size() && i < n; i++) begin
            checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL drop_byte%0d: got %h expected %h", i, got[base+i], exp[i]); end
        end
        checks++; if (clrLog.size() != cbase) begin errors++; $display("FAIL drop_clr: got %0d pulses expected 0", clrLog.size() - cbase); end
    endtask

    task automatic test_random();
        int base, cbase, n, nclr;
        logic to;
        logic [7:0] op, ch;
        for (int it = 0; it < 30; it++) begin
            busyMax = $urandom_range(0, 6);
            op = ($urandom_range(0, 1) == 1) ? OPZ : OPQ;
            ch = 8'($urandom_range(0, 7));
            for (int c = 0; c < NUM_CH; c++) count_flat[c*COUNT_W +: COUNT_W] = $urandom;
            base = got.size(); cbase = clrLog.size();
            model(op, ch, (ch < NUM_CH) ? cntOf(int'(ch)) : '0);
            sendByte(op, 1'b0); sendByte(ch, 1'b0);
            for (int c = 0; c < NUM_CH; c++) count_flat[c*COUNT_W +: COUNT_W] = $urandom;
            waitDone(to);
            checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: resp_active stuck high", it); end
            n = got.size() - base;
            checks++; if (n != exp.size()) begin errors++; $display("FAIL rand%0d_len: got %0d expected %0d", it, n, exp.size()); end
            for (int i = 0; i < exp.size() && i < n; i++) begin
                checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL rand%0d_byte%0d: got %h expected %h", it, i, got[base+i], exp[i]); end
            end
            nclr = (op == OPZ && ch < NUM_CH) ? 1 : 0;
            checks++; if (clrLog.size() - cbase != nclr) begin errors++; $display("FAIL rand%0d_clr_count: got %0d expected %0d", it, clrLog.size() - cbase, nclr); end
            if (nclr == 1 && clrLog.size() - cbase == 1) begin
                checks++; if (clrLog[cbase] !== (4'b0001 << ch)) begin errors++; $display("FAIL rand%0d_clr_value: got %b expected %b", it, clrLog[cbase], 4'b0001 << ch); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int base, n;
        logic to, seen;
        busyMax = 2;
        base = got.size();
        sendByte(OPQ, 1'b0); sendByte(8'h02, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (got.size() >= base + 3) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL midreset_third_byte: not started within bound"); end
        rst_n = 1'b0;
        #1;
        test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        n = got.size() - base;
        checks++; if (n != 3) begin errors++; $display("FAIL midreset_extra: got %0d bytes expected 3", n); end
        base = got.size();
        count_flat[0 +: COUNT_W] = 32'hCAFE0123;
        model(OPQ, 8'h00, 32'hCAFE0123);
        sendByte(OPQ, 1'b0); sendByte(8'h00, 1'b0);
        waitDone(to);
        n = got.size() - base;
        checks++; if (n != exp.size()) begin errors++; $display("FAIL after_reset_len: got %0d expected %0d", n, exp.size()); end
        for (int i = 0; i < exp.size() && i < n; i++) begin
            checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL after_reset_byte%0d: got %h expected %h", i, got[base+i], exp[i]); end
        end
    endtask

    initial begin
        rst_n = 1'b0; rx_data_ready = 1'b0; rx_data = 8'h00; rx_endofpacket = 1'b0;
        count_flat = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_query();
        test_clear();
        test_nak();
        test_abort_ignore();
        test_drop_during_reply();
        busyMax = 0;
        test_drop_during_reply();
        test_random();
        test_reset_midframe();
        checks++; if (busyViol != 0) begin errors++; $display("FAIL start_while_busy: got %0d violations expected 0", busyViol); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
